// File: rtl/pixel_prefetch_if.sv
// Prefetch <-> SDRAM mux / pixel FIFO signal bundle.
// FRAME_SWAP_EN adds the i_Swap double-buffer select.
interface pixel_prefetch_if;
  logic        i_Begin;
  logic [9:0]  i_Pixel_In_Used;
  logic        i_SDRAM_Grant;
  logic        i_Data_Read_Valid;
`ifdef FRAME_SWAP_EN
  logic        i_Swap;
`endif
  logic        o_SDRAM_Request;
  logic [1:0]  o_Command;
  logic [21:0] o_Data_Address;
  logic        o_FIFO_Wr;
  logic        o_First_Data_Ready;
  logic        o_Frame_Wrap;

  modport master (
    input  i_Begin, i_Pixel_In_Used, i_SDRAM_Grant, i_Data_Read_Valid,
`ifdef FRAME_SWAP_EN
    input  i_Swap,
`endif
    output o_SDRAM_Request, o_Command, o_Data_Address, o_FIFO_Wr,
    output o_First_Data_Ready, o_Frame_Wrap
  );

  modport slave (
    output i_Begin, i_Pixel_In_Used, i_SDRAM_Grant, i_Data_Read_Valid,
`ifdef FRAME_SWAP_EN
    output i_Swap,
`endif
    input  o_SDRAM_Request, o_Command, o_Data_Address, o_FIFO_Wr,
    input  o_First_Data_Ready, o_Frame_Wrap
  );
endinterface

// File: rtl/pixel_prefetch.sv
// Burst-reads the 8bpp framebuffer from SDRAM into the pixel FIFO, keeping it topped up.
// Optional FRAME_SWAP_EN: double-buffered frame base selected by i_Swap at each frame wrap.
module pixel_prefetch #(
  parameter logic [21:0] FRAME_BASE   = 22'h000000,
`ifdef FRAME_SWAP_EN
  parameter logic [21:0] FRAME_BASE_B = 22'h020000,
`endif
  parameter int          FRAME_WORDS  = 96000,
  parameter int          BURST        = 8,
  parameter int          FIFO_DEPTH   = 1024,
  parameter int          PRIME_WORDS  = 256,
  parameter logic [1:0]  CMD_NOP      = 2'd0,
  parameter logic [1:0]  CMD_READ     = 2'd1
) (
  input logic               i_Clk,
  input logic               i_Reset,
  pixel_prefetch_if.master  bus
);
  localparam int          BW          = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int          PW          = $clog2(PRIME_WORDS + 1);
  localparam logic [21:0] BURST_W     = 22'(BURST);
  localparam logic [21:0] FRAME_W     = 22'(FRAME_WORDS);
  localparam logic [10:0] SPACE_LIMIT = 11'(FIFO_DEPTH - 2 * BURST);

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQUEST, ISSUE, RECEIVE} state_t;

  state_t          state, state_nxt;
  logic [21:0]     addr, frame_base, next_base;
  logic [BW-1:0]   beat;
  logic [PW-1:0]   prime_cnt;
  logic            primed, wrap_q;
  logic            req, wr, last_beat, space_ok;
  logic [1:0]      cmd;

  assign space_ok  = {1'b0, bus.i_Pixel_In_Used} <= SPACE_LIMIT;
  assign last_beat = (state == RECEIVE) && bus.i_Data_Read_Valid && (beat == BW'(BURST - 1));

`ifdef FRAME_SWAP_EN
  assign next_base = bus.i_Swap ? FRAME_BASE_B : FRAME_BASE;
`else
  assign next_base = FRAME_BASE;
`endif

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    cmd       = CMD_NOP;
    wr        = 1'b0;
    case (state)
      IDLE:       if (bus.i_Begin) state_nxt = WAIT_SPACE;
      WAIT_SPACE: begin
        if (!bus.i_Begin)  state_nxt = IDLE;
        else if (space_ok) state_nxt = REQUEST;
      end
      REQUEST: begin
        req = 1'b1;
        if (bus.i_SDRAM_Grant) state_nxt = ISSUE;
      end
      ISSUE: begin
        req       = 1'b1;
        cmd       = CMD_READ;
        state_nxt = RECEIVE;
      end
      RECEIVE: begin
        // Grant is not re-checked here: the controller has already committed the burst.
        req = 1'b1;
        wr  = bus.i_Data_Read_Valid;
        if (last_beat) state_nxt = bus.i_Begin ? WAIT_SPACE : IDLE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state      <= IDLE;
      addr       <= FRAME_BASE;
      frame_base <= FRAME_BASE;
      beat       <= '0;
      prime_cnt  <= '0;
      primed     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      wrap_q <= 1'b0;
      if (state == ISSUE)
        beat <= '0;
      else if (state == RECEIVE && bus.i_Data_Read_Valid)
        beat <= beat + 1'b1;
      if (last_beat) begin
        if (addr + BURST_W == frame_base + FRAME_W) begin
          addr       <= next_base;
          frame_base <= next_base;
          wrap_q     <= 1'b1;
        end else begin
          addr <= addr + BURST_W;
        end
      end
      // Saturating count; ready flag is sticky until reset.
      if (wr && prime_cnt != PW'(PRIME_WORDS)) prime_cnt <= prime_cnt + 1'b1;
      if (wr && prime_cnt == PW'(PRIME_WORDS - 1)) primed <= 1'b1;
    end
  end

  assign bus.o_SDRAM_Request    = req;
  assign bus.o_Command          = cmd;
  assign bus.o_Data_Address     = addr;
  assign bus.o_FIFO_Wr          = wr;
  assign bus.o_First_Data_Ready = primed;
  assign bus.o_Frame_Wrap       = wrap_q;
endmodule
